// File: rtl/laser_tx_pkg.sv
// laser_tx_pkg: shared types and constants for the laser frame transmitter.
//   tx_state_e    frame sequencer states (ST_CRC exists only with LASER_TX_CRC16_EN)
//   PAR_*         parity mode selectors
//   CRC_POLY/INIT CRC-16-CCITT constants, crc16_word() folds one 16-bit word MSB first
// Optional feature macro: LASER_TX_CRC16_EN
package laser_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FETCH,
    ST_SEND,
`ifdef LASER_TX_CRC16_EN
    ST_CRC,
`endif
    ST_GAP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned CRC_W    = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

`ifdef LASER_TX_CRC16_EN
  // Bitwise CRC-16-CCITT update, MSB of the word first, no reflection.
  function automatic logic [CRC_W-1:0] crc16_word(input logic [CRC_W-1:0] crc_in,
                                                   input logic [CRC_W-1:0] word);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = CRC_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ word[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/laser_bit_ser.sv
// laser_bit_ser: serialises one word as start(0), data LSB first, optional
// parity, STOP_BITS ones; every bit is held OSR clk cycles.
//   clk, rst_n  clock, async active-low reset
//   load        capture data; the start bit appears on tx_out the next cycle
//   data        word to send
//   tx_out      serial line (registered, idles high)
//   done_c      high in the final cycle of the last stop bit
module laser_bit_ser
  import laser_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned OSR         = 15,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx_out,
  output logic                 done_c
);

  localparam int unsigned PAR_BITS = (PARITY_MODE != PAR_NONE) ? 1 : 0;
  localparam int unsigned SH_W     = DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int unsigned N_BITS   = SH_W + 1;
  localparam int unsigned OSR_W    = $clog2(OSR);
  localparam int unsigned BIT_W    = $clog2(N_BITS);

  logic             active_q, active_d;
  logic             tx_q, tx_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [OSR_W-1:0] osr_cnt_q, osr_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]  frame_c;
  logic             osr_last_c;
  logic             bit_last_c;

  // Bits following the start bit; stop positions stay at their default of 1.
  always_comb begin
    frame_c                  = '1;
    frame_c[DATA_BITS-1:0]   = data;
    if (PARITY_MODE == PAR_EVEN) begin
      frame_c[DATA_BITS] = ^data;
    end else if (PARITY_MODE == PAR_ODD) begin
      frame_c[DATA_BITS] = ~^data;
    end
  end

  assign osr_last_c = (osr_cnt_q == OSR_W'(OSR - 1));
  assign bit_last_c = (bit_cnt_q == BIT_W'(N_BITS - 1));
  assign done_c     = active_q && osr_last_c && bit_last_c;

  // Bit timing: tx_q holds the current bit, sh_q queues the rest.
  always_comb begin
    active_d  = active_q;
    tx_d      = tx_q;
    sh_d      = sh_q;
    osr_cnt_d = osr_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      active_d  = 1'b1;
      tx_d      = 1'b0;
      sh_d      = frame_c;
      osr_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (active_q) begin
      if (osr_last_c) begin
        osr_cnt_d = '0;
        if (bit_last_c) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          tx_d      = sh_q[0];
          sh_d      = {1'b1, sh_q[SH_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end else begin
        osr_cnt_d = osr_cnt_q + OSR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      tx_q      <= 1'b1;
      sh_q      <= '1;
      osr_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      active_q  <= active_d;
      tx_q      <= tx_d;
      sh_q      <= sh_d;
      osr_cnt_q <= osr_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign tx_out = tx_q;

endmodule

// File: rtl/laser_frame_tx.sv
// laser_frame_tx: reads words from a source memory and sends them as framed
// bursts: SYNC word, up to BURST_LEN payload words, optional CRC word, idle gap.
//   clk, rst_n   clock, async active-low reset
//   start        begin transmission from address 0 (only honoured in IDLE)
//   mem_rd_en    read strobe, mem_addr read address, mem_data returns 1 cycle later
//   tx_out       serial line, idle high
//   busy         not IDLE
//   word_done    pulse after each payload word's last stop bit
//   frame_done   pulse when the inter-frame gap completes
//   all_done     pulse with frame_done for the frame that sent address ADDR_MAX-1
// Optional feature macro: LASER_TX_CRC16_EN (CRC-16-CCITT word per frame, DATA_BITS=16 only)
module laser_frame_tx
  import laser_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned OSR         = 15,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned ADDR_MAX    = 40000,
  parameter logic [31:0] SYNC_WORD   = 32'h0000_A55A,
  parameter int unsigned GAP_BITS    = 8,
  parameter int unsigned CONTINUOUS  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        mem_rd_en,
  output logic [$clog2(ADDR_MAX)-1:0] mem_addr,
  input  logic [DATA_BITS-1:0]        mem_data,
  output logic                        tx_out,
  output logic                        busy,
  output logic                        word_done,
  output logic                        frame_done,
  output logic                        all_done
);

  localparam int unsigned AW      = $clog2(ADDR_MAX);
  localparam int unsigned BL_W    = $clog2(BURST_LEN + 1);
  localparam int unsigned GAP_CYC = GAP_BITS * OSR;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [AW-1:0]        ADDR_LAST = AW'(ADDR_MAX - 1);
  localparam logic [DATA_BITS-1:0] SYNC_W    = SYNC_WORD[DATA_BITS-1:0];

`ifdef LASER_TX_CRC16_EN
  if (DATA_BITS != 16) begin : g_crc_width_chk
    $error("laser_frame_tx: LASER_TX_CRC16_EN requires DATA_BITS == 16");
  end
`endif

  tx_state_e          state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic               fetch_ph_q, fetch_ph_d;
  logic [BL_W-1:0]    wcnt_q, wcnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               word_done_q, word_done_d;
  logic               frame_done_q, frame_done_d;
  logic               all_done_q, all_done_d;
`ifdef LASER_TX_CRC16_EN
  logic [CRC_W-1:0]   crc_q, crc_d;
`endif

  logic                 ser_load_c;
  logic [DATA_BITS-1:0] ser_data_c;
  logic                 ser_done_c;
  logic                 addr_last_c;
  logic                 burst_last_c;

  assign addr_last_c  = (addr_q == ADDR_LAST);
  assign burst_last_c = (wcnt_q == BL_W'(BURST_LEN - 1));

  // Frame sequencer; serializer loads are issued on the transition edge so the
  // first bit of each word follows immediately.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    fetch_ph_d   = 1'b0;
    wcnt_d       = wcnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_d       = last_q;
    word_done_d  = 1'b0;
    frame_done_d = 1'b0;
    all_done_d   = 1'b0;
    ser_load_c   = 1'b0;
    ser_data_c   = SYNC_W;
`ifdef LASER_TX_CRC16_EN
    crc_d        = crc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SYNC;
          ser_load_c = 1'b1;
          addr_d     = '0;
          wcnt_d     = '0;
          last_d     = 1'b0;
`ifdef LASER_TX_CRC16_EN
          crc_d      = CRC_INIT;
`endif
        end
      end
      ST_SYNC: begin
        if (ser_done_c) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // Phase 0 issues the read, phase 1 sees the returned data.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          state_d    = ST_SEND;
          ser_load_c = 1'b1;
          ser_data_c = mem_data;
`ifdef LASER_TX_CRC16_EN
          crc_d      = crc16_word(crc_q, CRC_W'(mem_data));
`endif
        end
      end
      ST_SEND: begin
        if (ser_done_c) begin
          word_done_d = 1'b1;
          wcnt_d      = wcnt_q + BL_W'(1);
          addr_d      = addr_last_c ? '0 : addr_q + AW'(1);
          if (addr_last_c) last_d = 1'b1;
          if (addr_last_c || burst_last_c) begin
`ifdef LASER_TX_CRC16_EN
            state_d    = ST_CRC;
            ser_load_c = 1'b1;
            ser_data_c = DATA_BITS'(crc_q);
`else
            state_d   = ST_GAP;
            gap_cnt_d = '0;
`endif
          end else begin
            state_d = ST_FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
`ifdef LASER_TX_CRC16_EN
      ST_CRC: begin
        if (ser_done_c) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          frame_done_d = 1'b1;
          all_done_d   = last_q;
          wcnt_d       = '0;
          last_d       = 1'b0;
`ifdef LASER_TX_CRC16_EN
          crc_d        = CRC_INIT;
`endif
          // addr_q already wrapped to 0 after the last source word.
          if (last_q && (CONTINUOUS == 0)) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_SYNC;
            ser_load_c = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      fetch_ph_q   <= 1'b0;
      wcnt_q       <= '0;
      gap_cnt_q    <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      all_done_q   <= 1'b0;
`ifdef LASER_TX_CRC16_EN
      crc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      fetch_ph_q   <= fetch_ph_d;
      wcnt_q       <= wcnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
      frame_done_q <= frame_done_d;
      all_done_q   <= all_done_d;
`ifdef LASER_TX_CRC16_EN
      crc_q        <= crc_d;
`endif
    end
  end

  laser_bit_ser #(
    .DATA_BITS  (DATA_BITS),
    .OSR        (OSR),
    .PARITY_MODE(PARITY_MODE),
    .STOP_BITS  (STOP_BITS)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load_c),
    .data  (ser_data_c),
    .tx_out(tx_out),
    .done_c(ser_done_c)
  );

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign frame_done = frame_done_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_laser_frame_tx.sv
// tb_laser_frame_tx: three transmitter configurations driven from one random
// source memory; every cycle of each run is compared against a per-cycle line
// model built from the word/frame rules.
//   u_dut0: 8b (16b with CRC), OSR 4, even parity, 1 stop, burst 2, 5 words, one-shot
//   u_dut1: as u_dut0 but odd parity and continuous
//   u_dut2: no parity, 2 stop bits, burst 3, 7 words, gap 3
`timescale 1ns/1ps
module tb_laser_frame_tx;

`ifdef LASER_TX_CRC16_EN
  localparam int unsigned DB      = 16;
  localparam bit          HAS_CRC = 1'b1;
`else
  localparam int unsigned DB      = 8;
  localparam bit          HAS_CRC = 1'b0;
`endif
  localparam int unsigned NDUT = 3;
  localparam logic [31:0] SYNC32 = 32'h0000_A55A;

  logic clk = 1'b0;
  logic rst_n;
  logic start_v [NDUT];
  wire  [NDUT-1:0] tx_v, busy_v, rd_v, wd_v, fd_v, ad_v;
  wire  [2:0]      addr_v [NDUT];
  logic [DB-1:0]   data_v [NDUT];
  logic [DB-1:0]   mem [8];

  always #5 clk = ~clk;

  // Source memory: data valid only the cycle after a read, junk otherwise.
  always @(posedge clk)
    for (int g = 0; g < NDUT; g++)
      data_v[g] <= rd_v[g] ? mem[addr_v[g]] : DB'($urandom);

  laser_frame_tx #(.DATA_BITS(DB), .OSR(4), .PARITY_MODE(1), .STOP_BITS(1),
    .BURST_LEN(2), .ADDR_MAX(5), .GAP_BITS(2), .CONTINUOUS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mem_rd_en(rd_v[0]),
    .mem_addr(addr_v[0]), .mem_data(data_v[0]), .tx_out(tx_v[0]), .busy(busy_v[0]),
    .word_done(wd_v[0]), .frame_done(fd_v[0]), .all_done(ad_v[0]));

  laser_frame_tx #(.DATA_BITS(DB), .OSR(4), .PARITY_MODE(2), .STOP_BITS(1),
    .BURST_LEN(2), .ADDR_MAX(5), .GAP_BITS(2), .CONTINUOUS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mem_rd_en(rd_v[1]),
    .mem_addr(addr_v[1]), .mem_data(data_v[1]), .tx_out(tx_v[1]), .busy(busy_v[1]),
    .word_done(wd_v[1]), .frame_done(fd_v[1]), .all_done(ad_v[1]));

  laser_frame_tx #(.DATA_BITS(DB), .OSR(4), .PARITY_MODE(0), .STOP_BITS(2),
    .BURST_LEN(3), .ADDR_MAX(7), .GAP_BITS(3), .CONTINUOUS(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mem_rd_en(rd_v[2]),
    .mem_addr(addr_v[2]), .mem_data(data_v[2]), .tx_out(tx_v[2]), .busy(busy_v[2]),
    .word_done(wd_v[2]), .frame_done(fd_v[2]), .all_done(ad_v[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Active configuration for the reference model.
  int c_osr, c_par, c_stop, c_burst, c_amax, c_gap;
  bit c_cont;

  task automatic set_cfg(input int s);
    c_osr = 4; c_par = 1; c_stop = 1; c_burst = 2; c_amax = 5; c_gap = 2; c_cont = 0;
    case (s)
      1: begin c_par = 2; c_cont = 1; end
      2: begin c_par = 0; c_stop = 2; c_burst = 3; c_amax = 7; c_gap = 3; end
      default: ;
    endcase
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 8; i++) mem[i] = DB'($urandom);
`ifdef LASER_TX_CRC16_EN
    mem[0] = 16'h3132;
    mem[1] = 16'h3334;
`else
    mem[0] = 8'hA5;
`endif
  endtask

  // Expected outputs, one entry per clk cycle starting the cycle after start.
  typedef struct {
    bit tx; bit busy; bit rd; int addr; bit wd; bit fd; bit ad;
  } cyc_t;
  cyc_t exp_q[$];
  bit pend_wd, pend_fd, pend_ad;

  // Pulses are registered, so they land on the cycle following their cause.
  function automatic void push_cyc(bit tx, bit bsy, bit rd, int addr);
    cyc_t c;
    c.tx = tx; c.busy = bsy; c.rd = rd; c.addr = addr;
    c.wd = pend_wd; c.fd = pend_fd; c.ad = pend_ad;
    pend_wd = 0; pend_fd = 0; pend_ad = 0;
    exp_q.push_back(c);
  endfunction

  function automatic void push_word(logic [DB-1:0] w);
    bit b[$];
    int ones;
    ones = $countones(w);
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(w[i]);
    if (c_par == 1) b.push_back((ones % 2) == 1);
    if (c_par == 2) b.push_back((ones % 2) == 0);
    for (int i = 0; i < c_stop; i++) b.push_back(1'b1);
    foreach (b[i]) repeat (c_osr) push_cyc(b[i], 1'b1, 1'b0, 0);
  endfunction

  function automatic logic [15:0] crc_model(logic [15:0] crc, logic [15:0] w);
    bit top;
    for (int i = 15; i >= 0; i--) begin
      top = crc[15] ^ w[i];
      crc = crc << 1;
      if (top) crc = crc ^ 16'h1021;
    end
    return crc;
  endfunction

  task automatic build_model(input int max_cycles);
    int addr;
    int n;
    bit last;
    logic [15:0] crc;
    logic [DB-1:0] sync_w;
    sync_w = SYNC32[DB-1:0];
    exp_q.delete();
    pend_wd = 0; pend_fd = 0; pend_ad = 0;
    addr = 0;
    while (exp_q.size() < max_cycles) begin
      push_word(sync_w);
      n = 0; crc = 16'hFFFF; last = 0;
      do begin
        push_cyc(1'b1, 1'b1, 1'b1, addr);
        push_cyc(1'b1, 1'b1, 1'b0, 0);
        push_word(mem[addr]);
        crc = crc_model(crc, 16'(mem[addr]));
        pend_wd = 1;
        n++;
        last = (addr == c_amax - 1);
        addr = last ? 0 : addr + 1;
      end while (!last && n < c_burst);
      if (HAS_CRC) push_word(DB'(crc));
      repeat (c_gap * c_osr) push_cyc(1'b1, 1'b1, 1'b0, 0);
      pend_fd = 1;
      pend_ad = last;
      if (last && !c_cont) begin
        repeat (4) push_cyc(1'b1, 1'b0, 1'b0, 0);
        break;
      end
    end
  endtask

  task automatic check_idle(input int s, input string pfx);
    check_eq({pfx, "_tx"}, 32'(tx_v[s]), 32'd1);
    check_eq({pfx, "_busy"}, 32'(busy_v[s]), 32'd0);
    check_eq({pfx, "_rd_en"}, 32'(rd_v[s]), 32'd0);
    check_eq({pfx, "_addr"}, 32'(addr_v[s]), 32'd0);
    check_eq({pfx, "_word_done"}, 32'(wd_v[s]), 32'd0);
    check_eq({pfx, "_frame_done"}, 32'(fd_v[s]), 32'd0);
    check_eq({pfx, "_all_done"}, 32'(ad_v[s]), 32'd0);
  endtask

  // Pulse start, then compare each model cycle; a second start at ign_idx
  // lands while busy and must change nothing. Stops after stop_idx if >= 0.
  task automatic run_check(input int s, input int ign_idx, input int stop_idx);
    @(negedge clk);
    start_v[s] = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      start_v[s] = (k == ign_idx);
      check_eq($sformatf("d%0d_tx[%0d]", s, k), 32'(tx_v[s]), 32'(exp_q[k].tx));
      check_eq($sformatf("d%0d_busy[%0d]", s, k), 32'(busy_v[s]), 32'(exp_q[k].busy));
      check_eq($sformatf("d%0d_rd_en[%0d]", s, k), 32'(rd_v[s]), 32'(exp_q[k].rd));
      if (exp_q[k].rd)
        check_eq($sformatf("d%0d_addr[%0d]", s, k), 32'(addr_v[s]), 32'(exp_q[k].addr));
      check_eq($sformatf("d%0d_word_done[%0d]", s, k), 32'(wd_v[s]), 32'(exp_q[k].wd));
      check_eq($sformatf("d%0d_frame_done[%0d]", s, k), 32'(fd_v[s]), 32'(exp_q[k].fd));
      check_eq($sformatf("d%0d_all_done[%0d]", s, k), 32'(ad_v[s]), 32'(exp_q[k].ad));
      if (k == stop_idx) return;
    end
    start_v[s] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int k0;
    int rk;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
    rand_mem();
    repeat (3) @(negedge clk);
    for (int s = 0; s < NDUT; s++) check_idle(s, $sformatf("rst_d%0d", s));
    rst_n = 1'b1;

    // One-shot run through all words, with a stray start while busy.
    set_cfg(0);
    rand_mem();
    build_model(100000);
    run_check(0, $urandom_range(exp_q.size() - 6, 1), -1);

    // Continuous: must wrap to address 0 and restart SYNC unprompted.
    set_cfg(1);
    rand_mem();
    build_model(900);
    run_check(1, $urandom_range(exp_q.size() - 6, 1), -1);

    // No parity, two stop bits, longer burst and gap.
    set_cfg(2);
    rand_mem();
    build_model(100000);
    run_check(2, $urandom_range(exp_q.size() - 6, 1), -1);

    // Async reset in the middle of a 0 payload bit, then a clean restart.
    set_cfg(0);
    rand_mem();
    build_model(100000);
    nb = 1 + DB + ((c_par != 0) ? 1 : 0) + c_stop;
    k0 = nb * c_osr + 2 + c_osr;
    rk = -1;
    for (int k = k0; k < exp_q.size(); k++)
      if (rk < 0 && exp_q[k].tx == 1'b0) rk = k + 1;
    run_check(0, -1, rk);
    #1 rst_n = 1'b0;
    #1 check_idle(0, "midbit_rst");
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_check(0, $urandom_range(exp_q.size() - 6, 1), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
